display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Time-shares the four 7-segment digits and the LEDs between three sources: the local clock view, manual page selection from the switches, and host-written content arriving over the USB Wishbone display register (endpoint 2).
- Sits between the switch inputs, the USB display register and `display_decoder`, which it feeds.
- Sequences automatic page cycling on the 10 ms `clk_en` tick.
- Grants the display to the host with a watchdog timeout.

Parameters:
- PAGE_TICKS, 300: `clk_en` ticks per page in AUTO mode (300 = 3 s); legal range ≥1.
- HOST_TIMEOUT, 500: `clk_en` ticks the host keeps the display after its last write (500 = 5 s); 0 = no timeout.

Ports:
- clk  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous reset, active-low
- clk_en  in  1  10 ms tick, single-cycle pulse
- sw_sel  in  3  manual page request from SW[2:0]
- auto_en  in  1  enable automatic page cycling
- host_wr  in  1  single-cycle pulse: host wrote the display register
- host_release  in  1  single-cycle pulse: host returns the display
- page  out  2  page to display_decoder: 0 hh:mm, 1 seconds, 2 weekday/day-of-month, 3 year/month
- host_active  out  1  1 = HEX/LED muxes select host register content
- page_stb  out  1  single-cycle pulse whenever page or host_active changes

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - mode=DEFAULT, page=0, host_active=0, page_stb=0.
  - page tick counter=0, host counter=0.
- Modes, evaluated every clk cycle, in priority order:
  - HOST: host grant held.
  - MANUAL: sw_sel≠0.
  - AUTO: auto_en=1.
  - DEFAULT: none of the above.
- MANUAL page encoding, highest set bit wins:
  - sw_sel[2] → 3
  - sw_sel[1] → 2
  - sw_sel[0] → 1
  - Example: sw_sel=3'b011 → page 2.
- DEFAULT: page=0.
- AUTO:
  - On entry from any other mode: page=0, tick counter=0.
  - Each clk_en increments the tick counter.
  - When the counter equals PAGE_TICKS-1 and clk_en=1: page←(page+1) mod 4 (3 wraps to 0), counter←0.
  - The counter holds while not in AUTO.
- HOST grant:
  - host_wr=1 → host_active←1, host counter←HOST_TIMEOUT, in every mode. A write during HOST reloads the counter.
  - While in HOST with HOST_TIMEOUT≠0: each clk_en decrements the counter. clk_en with counter=1 → counter←0, host_active←0, mode re-evaluated the next cycle.
  - host_release=1 → host_active←0 immediately (next edge).
  - page holds its pre-HOST value while host_active=1. page is don't-care downstream but must not change, so that page_stb does not fire.
- Simultaneous events:
  - host_wr and host_release in the same cycle: host_wr wins.
  - host_wr and clk_en: reload wins, no decrement.
  - clk_en coinciding with a mode change into AUTO: the entry reset wins.
- Outputs:
  - page, host_active and page_stb are all registered.
  - Latency from an input change to an output change is 1 clk cycle.
  - page_stb is high on exactly the cycle after page or host_active changed register value; it is never high for two consecutive cycles without a second change.
- Widths:
  - Tick counter: $clog2(PAGE_TICKS) bits, minimum 1.
  - Host counter: $clog2(HOST_TIMEOUT+1) bits, minimum 1.
  - No overflow is possible, because both counters are bounded by their compares.
- reset_n asserted mid-operation (AUTO or HOST) → all state returns to reset values immediately. No page_stb is generated by reset.
- sw_sel changes while in HOST have no visible effect until the grant ends.

Test Plan:
- Reset then idle, auto_en=0, sw_sel=0 → page=0, host_active=0, page_stb never asserted.
- PAGE_TICKS=4, auto_en=1, clk_en every 10 cycles:
  - page sequence is 0,1,2,3,0, changing on the 4th, 8th, 12th and 16th tick edge +1 cycle.
  - page_stb pulses once per change.
- AUTO running at page 2, then sw_sel=3'b101 → page=3 one cycle later. Then sw_sel=0 → AUTO re-entered with page=0 and the counter cleared.
- HOST_TIMEOUT=3, host_wr at tick 0 → host_active=1 the next cycle, then cleared one cycle after the 3rd clk_en.
  - A second host_wr after the 2nd tick extends the grant to 3 further ticks.
  - page_stb pulses at grant and at release.
- host_wr and host_release in the same cycle → host_active=1. host_release alone later → host_active=0 on the next edge.
- Async reset asserted mid-HOST with the counter at 2 → outputs zero without waiting for a clk edge; no page_stb after deassertion.

Source files
------------

// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - page request/grant signals between switches, USB display register and decoder.
interface display_scheduler_if;
  logic       clk_en;
  logic [2:0] sw_sel;
  logic       auto_en;
  logic       host_wr;
  logic       host_release;
  logic [1:0] page;
  logic       host_active;
  logic       page_stb;

  modport master (
    output clk_en, sw_sel, auto_en, host_wr, host_release,
    input  page, host_active, page_stb
  );

  modport slave (
    input  clk_en, sw_sel, auto_en, host_wr, host_release,
    output page, host_active, page_stb
  );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - arbitrates display pages between clock view, switches and host writes.
module display_scheduler #(
  parameter int PAGE_TICKS   = 300,
  parameter int HOST_TIMEOUT = 500
) (
  input  logic                clk,
  input  logic                reset_n,
  display_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    M_DEFAULT = 2'd0,
    M_AUTO    = 2'd1,
    M_MANUAL  = 2'd2,
    M_HOST    = 2'd3
  } mode_t;

  localparam int TW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam int HW = (HOST_TIMEOUT > 0) ? $clog2(HOST_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(PAGE_TICKS - 1);
  localparam logic [HW-1:0] HOST_LOAD = HW'(HOST_TIMEOUT);

  mode_t         r_mode;
  logic [1:0]    r_page;
  logic          r_host_active;
  logic          r_page_stb;
  logic [TW-1:0] r_tcnt;
  logic [HW-1:0] r_hcnt;

  mode_t         w_mode;
  logic [1:0]    w_page;
  logic [1:0]    w_manual_page;
  logic          w_host_active;
  logic          w_page_stb;
  logic [TW-1:0] w_tcnt;
  logic [HW-1:0] w_hcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= M_DEFAULT;
      r_page        <= 2'd0;
      r_host_active <= 1'b0;
      r_page_stb    <= 1'b0;
      r_tcnt        <= '0;
      r_hcnt        <= '0;
    end else begin
      r_mode        <= w_mode;
      r_page        <= w_page;
      r_host_active <= w_host_active;
      r_page_stb    <= w_page_stb;
      r_tcnt        <= w_tcnt;
      r_hcnt        <= w_hcnt;
    end
  end

  always_comb begin
    w_mode        = M_DEFAULT;
    w_page        = r_page;
    w_tcnt        = r_tcnt;
    w_host_active = r_host_active;
    w_hcnt        = r_hcnt;
    w_manual_page = 2'd1;

    if (bus.sw_sel[2])      w_manual_page = 2'd3;
    else if (bus.sw_sel[1]) w_manual_page = 2'd2;

    if (r_host_active)            w_mode = M_HOST;
    else if (bus.sw_sel != 3'd0)  w_mode = M_MANUAL;
    else if (bus.auto_en)         w_mode = M_AUTO;

    // In HOST the page is frozen so the grant edges alone raise page_stb.
    case (w_mode)
      M_HOST:   w_page = r_page;
      M_MANUAL: w_page = w_manual_page;
      M_AUTO: begin
        if (r_mode != M_AUTO) begin
          w_page = 2'd0;
          w_tcnt = '0;
        end else if (bus.clk_en) begin
          if (r_tcnt == TICK_LAST) begin
            w_page = r_page + 2'd1;
            w_tcnt = '0;
          end else begin
            w_tcnt = r_tcnt + TW'(1);
          end
        end
      end
      default:  w_page = 2'd0;
    endcase

    // A write outranks both release and a same-cycle timeout decrement.
    if (bus.host_wr) begin
      w_host_active = 1'b1;
      w_hcnt        = HOST_LOAD;
    end else if (bus.host_release) begin
      w_host_active = 1'b0;
    end else if (r_host_active && (HOST_TIMEOUT != 0) && bus.clk_en) begin
      if (r_hcnt == HW'(1)) begin
        w_hcnt        = '0;
        w_host_active = 1'b0;
      end else begin
        w_hcnt = r_hcnt - HW'(1);
      end
    end

    w_page_stb = (w_page != r_page) || (w_host_active != r_host_active);
  end

  assign bus.page        = r_page;
  assign bus.host_active = r_host_active;
  assign bus.page_stb    = r_page_stb;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - randomized and directed checks of display_scheduler against a behavioural model.
module tb_display_scheduler;
  localparam int PT = 4;
  localparam int HT = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  display_scheduler_if bus ();

  display_scheduler #(.PAGE_TICKS(PT), .HOST_TIMEOUT(HT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model state: mode codes 0 default, 1 auto, 2 manual, 3 host.
  int m_page, m_host, m_hcnt, m_ticks, m_prev, m_stb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int top_page(input logic [2:0] s);
    for (int b = 2; b >= 0; b--)
      if (s[b]) return b + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_page = 0; m_host = 0; m_hcnt = 0; m_ticks = 0; m_prev = 0; m_stb = 0;
  endtask

  task automatic model_step();
    int mode, np, nh;
    mode = m_host ? 3 : (bus.sw_sel != 0) ? 2 : bus.auto_en ? 1 : 0;
    np = m_page;
    if (mode == 2) np = top_page(bus.sw_sel);
    else if (mode == 0) np = 0;
    else if (mode == 1) begin
      if (m_prev != 1) begin
        np = 0;
        m_ticks = 0;
      end else if (bus.clk_en) begin
        m_ticks++;
        if (m_ticks == PT) begin
          np = (m_page + 1) % 4;
          m_ticks = 0;
        end
      end
    end
    nh = m_host;
    if (bus.host_wr) begin
      nh = 1;
      m_hcnt = HT;
    end else if (bus.host_release) begin
      nh = 0;
    end else if (m_host == 1 && HT != 0 && bus.clk_en) begin
      m_hcnt--;
      if (m_hcnt == 0) nh = 0;
    end
    m_stb  = (np != m_page || nh != m_host) ? 1 : 0;
    m_page = np;
    m_host = nh;
    m_prev = mode;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("page", bus.page, m_page);
    chk("host_active", bus.host_active, m_host);
    chk("page_stb", bus.page_stb, m_stb);
  endtask

  task automatic drive(input logic ce, input logic [2:0] sw, input logic ae,
                       input logic wr, input logic rel);
    bus.clk_en = ce; bus.sw_sel = sw; bus.auto_en = ae;
    bus.host_wr = wr; bus.host_release = rel;
  endtask

  task automatic run_ticks(input int cycles, input int period);
    for (int i = 0; i < cycles; i++) begin
      bus.clk_en = (i % period == period - 1);
      step();
    end
    bus.clk_en = 1'b0;
  endtask

  initial begin
    int seq[$];
    int exp_seq[4];
    exp_seq = '{1, 2, 3, 0};

    reset_n = 1'b0;
    drive(0, 3'd0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_page", bus.page, 0);
    chk("rst_host", bus.host_active, 0);
    chk("rst_stb", bus.page_stb, 0);
    reset_n = 1'b1;
    repeat (20) step();

    // Auto cycling through all four pages
    bus.auto_en = 1'b1;
    for (int i = 0; i < 165; i++) begin
      bus.clk_en = (i % 10 == 9);
      step();
      if (bus.page_stb) seq.push_back(int'(bus.page));
    end
    bus.clk_en = 1'b0;
    chk("auto_stb_count", seq.size(), 4);
    for (int k = 0; k < 4 && k < seq.size(); k++) chk("auto_seq", seq[k], exp_seq[k]);

    for (int i = 0; i < 200 && m_page != 2; i++) begin
      bus.clk_en = (i % 10 == 9);
      step();
    end
    bus.clk_en = 1'b0;
    chk("auto_at2", bus.page, 2);
    bus.sw_sel = 3'b101;
    step();
    chk("manual_101", bus.page, 3);
    bus.sw_sel = 3'b000;
    step();
    chk("auto_reentry", bus.page, 0);
    run_ticks(30, 10);
    chk("auto_cleared", bus.page, 0);
    run_ticks(10, 10);
    chk("auto_after4", bus.page, 1);

    // Host grant with timeout
    bus.host_wr = 1'b1; step(); bus.host_wr = 1'b0;
    chk("grant", bus.host_active, 1);
    for (int i = 0; i < 15; i++) begin
      bus.clk_en = (i % 5 == 4);
      if (i == 14) chk("pre_timeout", bus.host_active, 1);
      step();
    end
    bus.clk_en = 1'b0;
    chk("timeout", bus.host_active, 0);

    // Reload after two ticks extends by three more
    bus.host_wr = 1'b1; step(); bus.host_wr = 1'b0;
    run_ticks(10, 5);
    bus.host_wr = 1'b1; step(); bus.host_wr = 1'b0;
    run_ticks(10, 5);
    chk("extended", bus.host_active, 1);
    run_ticks(5, 5);
    chk("extended_end", bus.host_active, 0);

    drive(0, 3'd0, 1, 1, 1); step();
    chk("wr_beats_rel", bus.host_active, 1);
    drive(0, 3'd0, 1, 0, 0); repeat (3) step();
    bus.host_release = 1'b1; step(); bus.host_release = 1'b0;
    chk("release", bus.host_active, 0);

    // Async reset mid-grant with the host counter at 2
    bus.sw_sel = 3'b100; step();
    bus.host_wr = 1'b1; step(); bus.host_wr = 1'b0;
    bus.sw_sel = 3'b001; step();
    chk("sw_in_host", bus.page, 3);
    bus.clk_en = 1'b1; step(); bus.clk_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_page", bus.page, 0);
    chk("async_host", bus.host_active, 0);
    chk("async_stb", bus.page_stb, 0);
    model_reset();
    drive(0, 3'd0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step();
    chk("post_rst_stb", bus.page_stb, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.clk_en       = ($urandom_range(0, 7) == 0);
      bus.host_wr      = ($urandom_range(0, 49) == 0);
      bus.host_release = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0)
        bus.sw_sel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) bus.auto_en = ~bus.auto_en;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
